// File: rtl/execute_muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : execute_muldiv_pkg
// Description : Function codes and state encoding shared by the multi-cycle
//               multiply/divide unit and its neighbours in the execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
package execute_muldiv_pkg;

    // HI/LO move function codes
    localparam logic [5:0] MFHI_FUNC  = 6'h10;
    localparam logic [5:0] MTHI_FUNC  = 6'h11;
    localparam logic [5:0] MFLO_FUNC  = 6'h12;
    localparam logic [5:0] MTLO_FUNC  = 6'h13;

    // Iterative multiply/divide function codes
    localparam logic [5:0] MULT_FUNC  = 6'h18;
    localparam logic [5:0] MULTU_FUNC = 6'h19;
    localparam logic [5:0] DIV_FUNC   = 6'h1A;
    localparam logic [5:0] DIVU_FUNC  = 6'h1B;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FIXUP = 2'd2
    } md_state_e;

    // True for the four function codes that launch an iterative operation
    function automatic logic is_muldiv(input logic [5:0] f);
        return (f == MULT_FUNC) || (f == MULTU_FUNC) ||
               (f == DIV_FUNC)  || (f == DIVU_FUNC);
    endfunction

endpackage
`default_nettype wire

// File: rtl/execute_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : execute_muldiv
// Description : Iterative MIPS multiply/divide unit with HI/LO registers.
//               One multiplier/quotient bit per cycle, signs applied in a
//               final fixup cycle. MT* writes in one cycle, MF* reads are
//               combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module execute_muldiv
    import execute_muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] mf_result
);

    localparam int             W2       = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    // Accumulator: multiply = {partial product, remaining multiplier bits};
    // divide = {partial remainder, dividend bits / quotient bits}
    logic [W2-1:0]      acc_q,   acc_d;
    logic [WIDTH-1:0]   opb_q,   opb_d;
    logic               is_div_q, is_div_d;
    logic               sa_q,    sa_d;
    logic               sb_q,    sb_d;
    logic               done_q,  done_d;
    logic [WIDTH-1:0]   hi_q,    hi_d;
    logic [WIDTH-1:0]   lo_q,    lo_d;

    logic               is_signed;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     mul_sum;
    logic [W2-1:0]      mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_sub;
    logic [W2-1:0]      div_next;
    logic [W2-1:0]      prod_fix;

    // Operand magnitude capture and one-bit multiply / restoring-divide steps
    always_comb begin
        is_signed = (funct == MULT_FUNC) || (funct == DIV_FUNC);
        a_abs     = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
        b_abs     = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

        mul_sum   = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};

        // Partial remainder is WIDTH+1 bits after pulling in the next dividend bit
        div_shift = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
        div_sub   = div_shift[WIDTH-1:0] - opb_q;
        if (div_shift >= {1'b0, opb_q}) begin
            div_next = {div_sub, acc_q[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end

        prod_fix  = (sa_q ^ sb_q) ? (~acc_q + 1'b1) : acc_q;
    end

    // Next-state, iteration and HI/LO write control
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        is_div_d = is_div_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_muldiv(funct)) begin
                        state_d  = ST_CALC;
                        cnt_d    = '0;
                        acc_d    = {{WIDTH{1'b0}}, a_abs};
                        opb_d    = b_abs;
                        is_div_d = (funct == DIV_FUNC) || (funct == DIVU_FUNC);
                        sa_d     = is_signed & a[WIDTH-1];
                        sb_d     = is_signed & b[WIDTH-1];
                    end else if (funct == MTHI_FUNC) begin
                        hi_d = a;
                    end else if (funct == MTLO_FUNC) begin
                        lo_d = a;
                    end
                end
            end
            ST_CALC: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_FIXUP;
                end
            end
            ST_FIXUP: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                done_d  = 1'b1;
                if (is_div_q) begin
                    // Zero divisor leaves an all-ones quotient; the remainder
                    // is |a|, so the dividend-sign fixup restores the original a
                    if ((sa_q ^ sb_q) && (opb_q != '0)) begin
                        lo_d = ~acc_q[WIDTH-1:0] + 1'b1;
                    end else begin
                        lo_d = acc_q[WIDTH-1:0];
                    end
                    hi_d = sa_q ? (~acc_q[W2-1:WIDTH] + 1'b1) : acc_q[W2-1:WIDTH];
                end else begin
                    hi_d = prod_fix[W2-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Squash wins over everything, including a same-cycle MT* write
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            done_d  = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            is_div_q <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            is_div_q <= is_div_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // Status outputs and combinational MF* read port
    always_comb begin
        busy      = (state_q != ST_IDLE);
        done      = done_q;
        hi        = hi_q;
        lo        = lo_q;
        mf_result = (funct == MFHI_FUNC) ? hi_q : lo_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_execute_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_execute_muldiv
// Description : Self-checking bench for execute_muldiv (WIDTH=32). Directed
//               cases plus randomized mult/div against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_execute_muldiv;
    import execute_muldiv_pkg::*;

    localparam int W = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          flush = 1'b0;
    logic [5:0]    funct = 6'h00;
    logic [W-1:0]  a     = '0;
    logic [W-1:0]  b     = '0;
    logic          busy, done;
    logic [W-1:0]  hi, lo, mf_result;

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0] hi_m = '0;
    logic [W-1:0] lo_m = '0;

    execute_muldiv #(.WIDTH(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .flush     (flush),
        .funct     (funct),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo),
        .mf_result (mf_result)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Architectural result {HI, LO} from plain integer arithmetic
    function automatic logic [63:0] ref_op(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
        int              sx, sy, q, r;
        longint          ps;
        longint unsigned pu;
        sx = x;
        sy = y;
        case (f)
            MULT_FUNC: begin
                ps = longint'(sx) * longint'(sy);
                return ps;
            end
            MULTU_FUNC: begin
                pu = {32'b0, x} * {32'b0, y};
                return pu;
            end
            DIV_FUNC: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = sx / sy;
                r = sx % sy;
                return {r, q};
            end
            default: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    function automatic logic [W-1:0] rnd_opnd();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            4:       return 32'(0 - $urandom_range(1, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    // Issue one iterative op; optionally poke start (mult and MTHI) mid-CALC
    task automatic do_op(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y, input bit poke);
        logic [63:0] exp;
        int          lat;
        bit          got, busy_drop;
        @(negedge clock);
        start = 1'b1; funct = f; a = x; b = y;
        @(posedge clock); #1;
        start = 1'b0;
        exp   = ref_op(f, x, y);
        a     = $urandom;
        b     = $urandom;
        check("busy_on_accept", {63'b0, busy}, 64'd1);
        lat = 0; got = 1'b0; busy_drop = 1'b0;
        while (!got && lat < 40) begin
            if (poke && lat == 10)      begin start = 1'b1; funct = MULTU_FUNC; end
            else if (poke && lat == 11) begin start = 1'b1; funct = MTHI_FUNC;  end
            else                        start = 1'b0;
            @(posedge clock); #1;
            lat++;
            if (done) got = 1'b1;
            else if (!busy) busy_drop = 1'b1;
        end
        start = 1'b0;
        check("latency", 64'(lat), 64'd33);
        check("busy_held", {63'b0, busy_drop}, 64'd0);
        check("busy_off_at_done", {63'b0, busy}, 64'd0);
        hi_m = exp[63:32];
        lo_m = exp[31:0];
        check("hi", {32'b0, hi}, {32'b0, hi_m});
        check("lo", {32'b0, lo}, {32'b0, lo_m});
        funct = MFHI_FUNC; #1;
        check("mfhi", {32'b0, mf_result}, {32'b0, hi_m});
        funct = MFLO_FUNC; #1;
        check("mflo", {32'b0, mf_result}, {32'b0, lo_m});
        @(posedge clock); #1;
        check("done_one_cycle", {63'b0, done}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ops [4];
        bit         done_seen;
        ops = '{MULT_FUNC, MULTU_FUNC, DIV_FUNC, DIVU_FUNC};

        // Reset state
        #1;
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_hi", {32'b0, hi}, 64'd0);
        check("rst_lo", {32'b0, lo}, 64'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Directed cases
        do_op(MULT_FUNC,  32'hFFFF_FFFD, 32'd5,         1'b0);
        do_op(MULTU_FUNC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_op(DIV_FUNC,   32'hFFFF_FFF9, 32'd2,         1'b0);
        do_op(DIVU_FUNC,  32'd7,         32'd0,         1'b0);
        do_op(DIV_FUNC,   32'hFFFF_FFF9, 32'd0,         1'b0);
        do_op(DIV_FUNC,   32'h8000_0000, 32'hFFFF_FFFF, 1'b1);

        // MTHI then read-after-write through MF*
        @(negedge clock);
        start = 1'b1; funct = MTHI_FUNC; a = 32'h1234;
        @(posedge clock); #1;
        start = 1'b0; hi_m = 32'h1234;
        funct = MFHI_FUNC; #1;
        check("mthi_raw", {32'b0, mf_result}, {32'b0, hi_m});
        check("mthi_no_busy", {62'b0, busy, done}, 64'd0);
        funct = MFLO_FUNC; #1;
        check("mflo_after_mthi", {32'b0, mf_result}, {32'b0, lo_m});

        // MTLO squashed by a simultaneous flush
        @(negedge clock);
        start = 1'b1; funct = MTLO_FUNC; a = ~lo_m; flush = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; flush = 1'b0;
        check("mtlo_flushed", {32'b0, lo}, {32'b0, lo_m});

        // Plain MTLO
        @(negedge clock);
        start = 1'b1; funct = MTLO_FUNC; a = 32'hCAFE_0001;
        @(posedge clock); #1;
        start = 1'b0; lo_m = 32'hCAFE_0001;
        check("mtlo", {32'b0, lo}, {32'b0, lo_m});

        // Flush mid-CALC
        @(negedge clock);
        start = 1'b1; funct = DIVU_FUNC; a = 32'd1000; b = 32'd7;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        #1; flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        check("flush_idle", {63'b0, busy}, 64'd0);
        done_seen = 1'b0;
        repeat (40) begin
            @(posedge clock); #1;
            if (done) done_seen = 1'b1;
        end
        check("flush_no_done", {63'b0, done_seen}, 64'd0);
        check("flush_hi", {32'b0, hi}, {32'b0, hi_m});
        check("flush_lo", {32'b0, lo}, {32'b0, lo_m});
        do_op(DIVU_FUNC, 32'd1000, 32'd7, 1'b0);

        // Asynchronous reset mid-CALC
        @(negedge clock);
        start = 1'b1; funct = MULT_FUNC; a = 32'd3; b = 32'd9;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (5) @(posedge clock);
        #3; reset = 1'b1; #1;
        check("areset_busy", {63'b0, busy}, 64'd0);
        check("areset_done", {63'b0, done}, 64'd0);
        check("areset_hi", {32'b0, hi}, 64'd0);
        check("areset_lo", {32'b0, lo}, 64'd0);
        hi_m = '0; lo_m = '0;
        @(negedge clock);
        reset = 1'b0;
        do_op(MULT_FUNC, 32'd3, 32'd9, 1'b0);

        // Randomized mult/div
        for (int i = 0; i < 40; i++) begin
            do_op(ops[$urandom_range(0, 3)], rnd_opnd(), rnd_opnd(), ($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/execute_muldiv.md
# execute_muldiv

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers, sitting beside the single-cycle execute ALU in the MIPS datapath. It executes MULT, MULTU, DIV, DIVU iteratively, one bit per cycle. It services MTHI/MTLO writes in one cycle and serves MFHI/MFLO reads combinationally. The control unit stalls the pipeline while `busy` is high.

## Interface
Parameters:
- `WIDTH`, default 32: operand and HI/LO width; must be ≥ 4 and even.
- `CNT_W`, default $clog2(WIDTH+1): iteration counter width.

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; qualified with `funct`, sampled only when `busy`=0.
- `flush`  in  1  cancel any in-flight operation (exception/branch squash).
- `funct`  in  6  MIPS function code of the request.
- `a`  in  WIDTH  rs operand.
- `b`  in  WIDTH  rt operand.
- `busy`  out  1  operation in flight; the pipeline must stall on mult/div/mf* requests.
- `done`  out  1  one-cycle pulse; HI/LO updated by an iterative op.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.
- `mf_result`  out  WIDTH  `hi` when `funct`=MFHI, else `lo` (combinational).

## Operation
- Funct codes: MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B, MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13. Any other funct with `start` is ignored.
- States:
  - IDLE → CALC on an accepted mult/div.
  - CALC → FIXUP when the counter reaches WIDTH.
  - FIXUP → IDLE unconditionally.
  - `busy` = (state ≠ IDLE).
- Operand capture on accept:
  - Signed ops store |a|, |b| and the sign flags (sa, sb).
  - Unsigned ops store a, b unchanged, with flags cleared.
- Multiply: radix-2 shift-add over a 2·WIDTH accumulator, one multiplier bit per CALC cycle.
- Divide: restoring division, one quotient bit per CALC cycle. The partial remainder is WIDTH+1 bits.
- FIXUP, multiply: negate the 2·WIDTH product if sa^sb. HI gets the upper half, LO the lower half.
- FIXUP, divide:
  - LO = quotient, negated if sa^sb.
  - HI = remainder, negated if sa.
- Divide by zero (b = 0): full latency, then HI = a and LO = all-ones, with no sign fixup.
- Signed overflow (−2^(W−1) / −1): LO = 0x80..0, HI = 0. This is the natural truncated result.
- MTHI/MTLO: when `busy`=0, `hi`/`lo` take `a` at the next edge. No `done`, no `busy`.
- `flush`:
  - Forces the state to IDLE at the next edge and clears the counter.
  - HI/LO are not written and `done` is not asserted.
  - `flush` takes priority over `start`, including a simultaneous MT*.
- `start` while `busy`=1 is ignored. Operand registers are frozen during CALC.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `hi` 0, `lo` 0, counter 0. Reset mid-operation behaves like `flush` but also zeroes HI/LO.
- Sequence for a start accepted at edge E:
  - `busy` is high from E.
  - CALC iterations occur on edges E+1 … E+WIDTH.
  - HI/LO are written and `done` is registered high at edge E+WIDTH+1. `busy` goes low at the same edge.
  - `done` is high for exactly one cycle.
- Latency is WIDTH+1 edges for all four ops, including divide-by-zero. Earliest back-to-back accept is at edge E+WIDTH+2.
- Read-after-write: `mf_result` reflects MT* and mult/div results in the cycle after the writing edge.

## Structure
- Funct constants (`MULT_FUNC`, `MULTU_FUNC`, `DIV_FUNC`, `DIVU_FUNC`, `MFHI_FUNC`, `MTHI_FUNC`, `MFLO_FUNC`, `MTLO_FUNC`) and the state encodings belong in the shared defines include, next to the existing shift funct codes.
- Single module. No sub-module is warranted: multiply and divide share the counter, the operand registers and the FIXUP negation logic.

## Test plan
All scenarios use WIDTH=32.
- MULT a=0xFFFFFFFD (−3), b=5 → `done` at edge E+33; HI=0xFFFFFFFF, LO=0xFFFFFFF1; `busy` high for 33 cycles.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV a=−7 (0xFFFFFFF9), b=2 → LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). DIVU a=7, b=0 → HI=7, LO=0xFFFFFFFF, same latency.
- DIV a=0x80000000, b=0xFFFFFFFF → LO=0x80000000, HI=0. A second `start` issued mid-CALC is ignored and the result is unchanged.
- MTHI a=0x1234 then MFLO/MFHI reads → `mf_result`=0x1234 for MFHI the next cycle. MTLO asserted together with `flush` → LO unchanged.
- Start DIVU, assert `flush` at E+10 → IDLE at E+11, no `done`, HI/LO retain prior values. Asserting `reset` mid-CALC instead → all outputs 0 immediately, without waiting for a clock edge.
